// File: rtl/ex_dmem_issue_pkg.sv
// Shared encodings for the EX-stage data-SRAM issue unit: memory-op bit positions,
// byte-select patterns and the serialization FSM states.
package ex_dmem_issue_pkg;

  localparam int MEMOP_WD = 8;

  // mem_op bit positions, {lb,lbu,lh,lhu,lw,sb,sh,sw}
  localparam int OP_LB  = 7;
  localparam int OP_LBU = 6;
  localparam int OP_LH  = 5;
  localparam int OP_LHU = 4;
  localparam int OP_LW  = 3;
  localparam int OP_SB  = 2;
  localparam int OP_SH  = 1;
  localparam int OP_SW  = 0;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  function automatic logic is_load(input logic [MEMOP_WD-1:0] op);
    return op[OP_LB] | op[OP_LBU] | op[OP_LH] | op[OP_LHU] | op[OP_LW];
  endfunction

  function automatic logic is_store(input logic [MEMOP_WD-1:0] op);
    return op[OP_SB] | op[OP_SH] | op[OP_SW];
  endfunction

endpackage

// File: rtl/ex_dmem_issue_if.sv
// Single-port data-SRAM request bus; the issue unit is the master, the SRAM the slave.
interface ex_dmem_issue_if #(
  parameter int AW = 32
);
  logic          en;
  logic [3:0]    wen;
  logic [AW-1:0] addr;
  logic [AW-1:0] wdata;
  logic [AW-1:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/ex_dmem_issue_lane_gen.sv
// Per-slot lane generator: byte select, write mask, replicated store data and alignment fault.
// Alignment checking is compiled in only when EX_DMEM_ALIGN_CHECK_EN is defined.
module dmem_lane_gen
  import ex_dmem_issue_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [MEMOP_WD-1:0] mem_op,
  input  logic                valid,
  input  logic [1:0]          addr_lo,
  input  logic [AW-1:0]       sdata,
  output logic [3:0]          sel,
  output logic [3:0]          wen,
  output logic [AW-1:0]       wdata,
  output logic                adel,
  output logic                ades,
  output logic                access
);

  logic is_byte;
  logic is_half;
  logic is_word;
  logic is_ld;
  logic is_st;

  always_comb begin
    is_byte = valid & (mem_op[OP_LB] | mem_op[OP_LBU] | mem_op[OP_SB]);
    is_half = valid & (mem_op[OP_LH] | mem_op[OP_LHU] | mem_op[OP_SH]);
    is_word = valid & (mem_op[OP_LW] | mem_op[OP_SW]);
    is_ld   = valid & is_load(mem_op);
    is_st   = valid & is_store(mem_op);

    if (is_byte) begin
      sel = 4'(SEL_BYTE << addr_lo);
    end else if (is_half) begin
      sel = addr_lo[1] ? 4'(SEL_HALF << 2) : SEL_HALF;
    end else if (is_word) begin
      sel = SEL_WORD;
    end else begin
      sel = 4'b0000;
    end

    if (is_st & mem_op[OP_SB]) begin
      wdata = {4{sdata[7:0]}};
    end else if (is_st & mem_op[OP_SH]) begin
      wdata = {2{sdata[15:0]}};
    end else if (is_st & mem_op[OP_SW]) begin
      wdata = sdata;
    end else begin
      wdata = '0;
    end

    wen    = is_st ? sel : 4'b0000;
    access = (is_ld | is_st) & ~adel & ~ades;
  end

`ifdef EX_DMEM_ALIGN_CHECK_EN
  logic misalign;

  always_comb begin
    misalign = (is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00));
    adel     = is_ld & misalign;
    ades     = is_st & misalign;
  end
`else
  assign adel = 1'b0;
  assign ades = 1'b0;
`endif

endmodule

// File: rtl/ex_dmem_issue.sv
// EX-stage data-SRAM request unit: serializes dual memory ops onto one SRAM port and
// buffers the slot-1 load word of a serialized pair for the MEM stage.
module ex_dmem_issue
  import ex_dmem_issue_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                hold,
  input  logic [MEMOP_WD-1:0] mem_op_i1,
  input  logic [MEMOP_WD-1:0] mem_op_i2,
  input  logic                valid_i1,
  input  logic                valid_i2,
  input  logic [AW-1:0]       addr_i1,
  input  logic [AW-1:0]       addr_i2,
  input  logic [AW-1:0]       sdata_i1,
  input  logic [AW-1:0]       sdata_i2,
  ex_dmem_issue_if.master     sram,
  output logic [3:0]          sel_i1,
  output logic [3:0]          sel_i2,
  output logic                adel_i1,
  output logic                adel_i2,
  output logic                ades_i1,
  output logic                ades_i2,
  output logic                stallreq,
  output logic [AW-1:0]       ld_buf,
  output logic                ld_buf_vld
);

  logic [3:0]    l1_sel, l1_wen, l2_sel, l2_wen;
  logic [AW-1:0] l1_wdata, l2_wdata;
  logic          l1_adel, l1_ades, l1_acc;
  logic          l2_adel, l2_ades, l2_acc;

  state_e        state_q, state_d;
  logic [AW-1:0] ld_buf_q, ld_buf_d;
  logic          ld_buf_vld_q, ld_buf_vld_d;
  logic          cap_q, cap_d;
  logic          adv_q, adv_d;

  logic fault_i1, mem1, mem2, pair, iss1, iss2, stall;

  dmem_lane_gen #(.AW(AW)) u_lane_i1 (
    .mem_op (mem_op_i1), .valid (valid_i1), .addr_lo (addr_i1[1:0]), .sdata (sdata_i1),
    .sel (l1_sel), .wen (l1_wen), .wdata (l1_wdata),
    .adel (l1_adel), .ades (l1_ades), .access (l1_acc)
  );

  dmem_lane_gen #(.AW(AW)) u_lane_i2 (
    .mem_op (mem_op_i2), .valid (valid_i2), .addr_lo (addr_i2[1:0]), .sdata (sdata_i2),
    .sel (l2_sel), .wen (l2_wen), .wdata (l2_wdata),
    .adel (l2_adel), .ades (l2_ades), .access (l2_acc)
  );

  always_comb begin
    fault_i1 = l1_adel | l1_ades;
    mem1     = l1_acc;
    // A slot-1 fault makes slot 2 invisible so the exception stays precise.
    mem2     = l2_acc & ~fault_i1;
    pair     = mem1 & mem2;

    state_d = state_q;
    iss1    = 1'b0;
    iss2    = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pair) begin
          iss1  = 1'b1;
          stall = 1'b1;
          if (!hold) begin
            state_d = ST_SECOND;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (mem1) begin
          iss1 = 1'b1;
        end else if (mem2) begin
          iss2 = 1'b1;
        end else begin
          iss1 = 1'b0;
        end
      end
      ST_SECOND: begin
        iss2 = 1'b1;
        if (!hold) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SECOND;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cap_d = (state_q == ST_IDLE) & pair & is_load(mem_op_i1) & ~hold & ~flush;
    adv_d = (state_q == ST_SECOND) & ~hold & ~flush;

    if (flush) begin
      state_d = ST_IDLE;
      stall   = 1'b0;
      iss1    = 1'b0;
      iss2    = 1'b0;
    end else if (hold) begin
      iss1 = 1'b0;
      iss2 = 1'b0;
    end else begin
      stall = stall;
    end

    // Flush beats a pending capture; a capture beats the bundle-advance clear.
    ld_buf_d     = ld_buf_q;
    ld_buf_vld_d = ld_buf_vld_q;
    if (flush) begin
      ld_buf_vld_d = 1'b0;
    end else if (cap_q) begin
      ld_buf_d     = sram.rdata;
      ld_buf_vld_d = 1'b1;
    end else if (adv_q) begin
      ld_buf_vld_d = 1'b0;
    end else begin
      ld_buf_vld_d = ld_buf_vld_q;
    end
  end

  always_comb begin
    sram.en    = 1'b0;
    sram.wen   = 4'b0000;
    sram.addr  = '0;
    sram.wdata = '0;
    sel_i1     = 4'b0000;
    sel_i2     = 4'b0000;
    adel_i1    = 1'b0;
    ades_i1    = 1'b0;
    adel_i2    = 1'b0;
    ades_i2    = 1'b0;
    stallreq   = 1'b0;
    if (rst) begin
      sel_i1   = l1_sel;
      sel_i2   = fault_i1 ? 4'b0000 : l2_sel;
      adel_i1  = l1_adel;
      ades_i1  = l1_ades;
      adel_i2  = l2_adel & ~fault_i1;
      ades_i2  = l2_ades & ~fault_i1;
      stallreq = stall;
      if (iss1) begin
        sram.en    = 1'b1;
        sram.wen   = l1_wen;
        sram.addr  = {addr_i1[AW-1:2], 2'b00};
        sram.wdata = l1_wdata;
      end else if (iss2) begin
        sram.en    = 1'b1;
        sram.wen   = l2_wen;
        sram.addr  = {addr_i2[AW-1:2], 2'b00};
        sram.wdata = l2_wdata;
      end else begin
        sram.en = 1'b0;
      end
    end else begin
      sram.en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ld_buf_q     <= '0;
      ld_buf_vld_q <= 1'b0;
      cap_q        <= 1'b0;
      adv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_buf_q     <= ld_buf_d;
      ld_buf_vld_q <= ld_buf_vld_d;
      cap_q        <= cap_d;
      adv_q        <= adv_d;
    end
  end

  assign ld_buf     = ld_buf_q;
  assign ld_buf_vld = ld_buf_vld_q;

endmodule

// File: tb/tb_ex_dmem_issue.sv
// Scoreboard bench for ex_dmem_issue: directed bundles push expected SRAM requests and
// captured load words; a negedge monitor pops and compares them as the DUT presents them.
module tb_ex_dmem_issue;

  localparam logic [7:0] OP_NONE = 8'h00;
  localparam logic [7:0] LHU = 8'h10, LH = 8'h20, LW = 8'h08;
  localparam logic [7:0] SB = 8'h04, SH = 8'h02, SW = 8'h01;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, hold;
  logic [7:0]  mem_op_i1, mem_op_i2;
  logic        valid_i1, valid_i2;
  logic [31:0] addr_i1, addr_i2, sdata_i1, sdata_i2;
  logic [3:0]  sel_i1, sel_i2;
  logic        adel_i1, adel_i2, ades_i1, ades_i2, stallreq, ld_buf_vld;
  logic [31:0] ld_buf;

  int checks   = 0;
  int failures = 0;
  req_t        sq[$];
  logic [31:0] lq[$];
  logic        prev_vld = 1'b0;

  ex_dmem_issue_if #(.AW(32)) sram_if ();

  ex_dmem_issue #(.AW(32)) dut (
    .clk (clk), .rst (rst), .flush (flush), .hold (hold),
    .mem_op_i1 (mem_op_i1), .mem_op_i2 (mem_op_i2),
    .valid_i1 (valid_i1), .valid_i2 (valid_i2),
    .addr_i1 (addr_i1), .addr_i2 (addr_i2),
    .sdata_i1 (sdata_i1), .sdata_i2 (sdata_i2),
    .sram (sram_if),
    .sel_i1 (sel_i1), .sel_i2 (sel_i2),
    .adel_i1 (adel_i1), .adel_i2 (adel_i2), .ades_i1 (ades_i1), .ades_i2 (ades_i2),
    .stallreq (stallreq), .ld_buf (ld_buf), .ld_buf_vld (ld_buf_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'hDEAD_BEEF;
    else if (a == 32'h0000_0300) return 32'hCAFE_F00D;
    else return 32'h5A5A_0000 | {16'h0000, a[15:0]};
  endfunction

  // SRAM responder: read data appears one cycle after an enabled access.
  always @(posedge clk or negedge rst) begin
    if (!rst) sram_if.rdata <= 32'h0000_0000;
    else if (sram_if.en) sram_if.rdata <= mem_rd(sram_if.addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every SRAM request and every fresh ld_buf word is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && sram_if.en === 1'b1) begin
      if (sq.size() == 0) begin
        check("unexpected_req_addr", sram_if.addr, 32'hFFFF_FFFF);
      end else begin
        req_t e;
        e = sq.pop_front();
        check("req_addr", sram_if.addr, e.addr);
        check("req_wen", 32'(sram_if.wen), 32'(e.wen));
        check("req_wdata", sram_if.wdata, e.wdata);
      end
    end
    if (rst === 1'b1 && ld_buf_vld === 1'b1 && prev_vld == 1'b0) begin
      if (lq.size() == 0) check("unexpected_ld_buf", ld_buf, 32'hFFFF_FFFF);
      else check("ld_buf", ld_buf, lq.pop_front());
    end
    prev_vld = ld_buf_vld;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] o1, input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [7:0] o2, input logic v2, input logic [31:0] a2, input logic [31:0] d2);
    mem_op_i1 = o1; valid_i1 = v1; addr_i1 = a1; sdata_i1 = d1;
    mem_op_i2 = o2; valid_i2 = v2; addr_i2 = a2; sdata_i2 = d2;
  endtask

  task automatic idle();
    drive(OP_NONE, 1'b0, 32'h0, 32'h0, OP_NONE, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    req_t r;
    r.addr = a; r.wen = w; r.wdata = d;
    sq.push_back(r);
  endtask

  initial begin
    flush = 1'b0; hold = 1'b0;
    rst = 1'b1;
    drive(SW, 1'b1, 32'h100, 32'h1122_3344, OP_NONE, 1'b0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_en", 32'(sram_if.en), 32'd0);
    check("rst_sel_i1", 32'(sel_i1), 32'd0);
    check("rst_stallreq", 32'(stallreq), 32'd0);
    check("rst_ld_buf", ld_buf, 32'd0);
    check("rst_ld_buf_vld", 32'(ld_buf_vld), 32'd0);
    step(); idle(); rst = 1'b1;
    step();

    // single store
    drive(SW, 1'b1, 32'h100, 32'h1122_3344, OP_NONE, 1'b0, 32'h0, 32'h0);
    push(32'h100, 4'b1111, 32'h1122_3344);
    @(negedge clk);
    check("t1_stallreq", 32'(stallreq), 32'd0);
    check("t1_sel_i1", 32'(sel_i1), 32'hF);
    step(); idle();

    // lw + sb pair, slot-1 load captured
    step();
    drive(LW, 1'b1, 32'h200, 32'h0, SB, 1'b1, 32'h203, 32'h0000_00AB);
    push(32'h200, 4'b0000, 32'h0);
    push(32'h200, 4'b1000, 32'hABAB_ABAB);
    lq.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    check("t2_stall_c0", 32'(stallreq), 32'd1);
    step();
    @(negedge clk);
    check("t2_stall_c1", 32'(stallreq), 32'd0);
    step(); idle();
    @(negedge clk);
    check("t2_vld", 32'(ld_buf_vld), 32'd1);
    step();

    // lw/lw pair with hold for three cycles in SECOND
    drive(LW, 1'b1, 32'h300, 32'h0, LW, 1'b1, 32'h304, 32'h0);
    push(32'h300, 4'b0000, 32'h0);
    push(32'h304, 4'b0000, 32'h0);
    lq.push_back(32'hCAFE_F00D);
    step(); hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("t4_hold_vld", 32'(ld_buf_vld), 32'd1);
        check("t4_hold_buf", ld_buf, 32'hCAFE_F00D);
      end
      step();
    end
    hold = 1'b0;
    @(negedge clk);
    check("t4_release_buf", ld_buf, 32'hCAFE_F00D);
    step(); idle();
    step(); step();
    @(negedge clk);
    check("t4_vld_cleared", 32'(ld_buf_vld), 32'd0);

    // pair flushed in SECOND, then a fresh pair proves the FSM is back in IDLE
    step();
    drive(LW, 1'b1, 32'h200, 32'h0, SW, 1'b1, 32'h208, 32'h55);
    push(32'h200, 4'b0000, 32'h0);
    step(); flush = 1'b1;
    @(negedge clk);
    check("t5_flush_stall", 32'(stallreq), 32'd0);
    step(); flush = 1'b0;
    drive(SB, 1'b1, 32'h401, 32'h77, SH, 1'b1, 32'h402, 32'h0000_BEEF);
    push(32'h400, 4'b0010, 32'h7777_7777);
    push(32'h400, 4'b1100, 32'hBEEF_BEEF);
    @(negedge clk);
    check("t5_vld_after_flush", 32'(ld_buf_vld), 32'd0);
    check("t5_new_pair_stall", 32'(stallreq), 32'd1);
    step();
    step(); idle();

    // slot-2-only load
    step();
    drive(OP_NONE, 1'b1, 32'h0, 32'h0, LHU, 1'b1, 32'h502, 32'h0);
    push(32'h500, 4'b0000, 32'h0);
    @(negedge clk);
    check("t7_stall", 32'(stallreq), 32'd0);
    check("t7_sel_i2", 32'(sel_i2), 32'hC);
    check("t7_sel_i1", 32'(sel_i1), 32'h0);
    step(); idle();

`ifdef EX_DMEM_ALIGN_CHECK_EN
    // misaligned slot-1 load suppresses slot 2 entirely
    step();
    drive(LH, 1'b1, 32'h101, 32'h0, SW, 1'b1, 32'h104, 32'h1);
    @(negedge clk);
    check("t3_adel_i1", 32'(adel_i1), 32'd1);
    check("t3_ades_i2", 32'(ades_i2), 32'd0);
    check("t3_sel_i2", 32'(sel_i2), 32'h0);
    check("t3_stall", 32'(stallreq), 32'd0);
    step();
    // slot-2 fault breaks the pair; slot 1 issues alone
    drive(LW, 1'b1, 32'h600, 32'h0, SW, 1'b1, 32'h602, 32'h1);
    push(32'h600, 4'b0000, 32'h0);
    @(negedge clk);
    check("t8_ades_i2", 32'(ades_i2), 32'd1);
    check("t8_stall", 32'(stallreq), 32'd0);
    step();
    drive(SH, 1'b1, 32'h103, 32'h1234, OP_NONE, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("t6_ades_i1", 32'(ades_i1), 32'd1);
    step(); idle();
`else
    // unchecked build: misaligned half store goes out with raw low address bits
    step();
    drive(SH, 1'b1, 32'h103, 32'h1234, OP_NONE, 1'b0, 32'h0, 32'h0);
    push(32'h100, 4'b1100, 32'h1234_1234);
    @(negedge clk);
    check("t6_ades_i1", 32'(ades_i1), 32'd0);
    check("t6_adel_i1", 32'(adel_i1), 32'd0);
    check("t6_sel_i1", 32'(sel_i1), 32'hC);
    step(); idle();
`endif

    step(); step();
    @(negedge clk);
    check("req_queue_drained", 32'(sq.size()), 32'd0);
    check("ld_queue_drained", 32'(lq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
